// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: turns a 2-bit mode (OFF/ON/BLINK/CHASE) into timed LED patterns.
// Optional PWM dimming output stage is enabled with `define LED_PWM_DIM_EN.
module led_pattern_sequencer #(
    parameter int CLK_DIV = 50000000,
    parameter int N_LEDS  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode_in,
    input  logic              hold,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]        dim_level,
`endif
    output logic [N_LEDS-1:0] leds,
    output logic              step_tick,
    output logic [1:0]        mode_cur
);

    localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    mode_t             state_q, state_d, s2_mode;
    logic [1:0]        sync_s1, sync_s2;
    logic [PW-1:0]     presc_q, presc_d;
    logic [N_LEDS-1:0] pattern_q, pattern_d;
    logic              tick_q, tick_d;

    // mode_in may come from another domain, so it is double-flopped before use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= 2'd0;
            sync_s2 <= 2'd0;
        end else begin
            sync_s1 <= mode_in;
            sync_s2 <= sync_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MODE_OFF;
            presc_q   <= '0;
            pattern_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pattern_q <= pattern_d;
            tick_q    <= tick_d;
        end
    end

    // A mode change takes priority over a coincident prescaler wrap.
    always_comb begin
        s2_mode   = mode_t'(sync_s2);
        state_d   = state_q;
        presc_d   = presc_q;
        pattern_d = pattern_q;
        tick_d    = 1'b0;
        if (s2_mode != state_q) begin
            state_d = s2_mode;
            presc_d = '0;
            case (s2_mode)
                MODE_OFF:   pattern_d = '0;
                MODE_ON:    pattern_d = '1;
                MODE_BLINK: pattern_d = '1;
                default:    pattern_d = N_LEDS'(1);
            endcase
        end else if (!hold) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                case (state_q)
                    MODE_BLINK: pattern_d = ~pattern_q;
                    MODE_CHASE: pattern_d = (pattern_q << 1) | (pattern_q >> (N_LEDS - 1));
                    default:    pattern_d = pattern_q;
                endcase
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign mode_cur  = state_q;
    assign step_tick = tick_q;

`ifdef LED_PWM_DIM_EN
    logic [3:0]        pwm_cnt;
    logic [N_LEDS-1:0] leds_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= 4'd0;
            leds_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            leds_q  <= pattern_q & {N_LEDS{pwm_cnt <= dim_level}};
        end
    end

    assign leds = leds_q;
`else
    assign leds = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (CLK_DIV=4, N_LEDS=4) against a step-count model.
module tb_led_pattern_sequencer;
  localparam int CLK_DIV = 4;
  localparam int N_LEDS  = 4;
  localparam int W       = N_LEDS + 3;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        mode_in = 2'd0;
  logic              hold    = 1'b0;
`ifdef LED_PWM_DIM_EN
  logic [3:0]        dim_level = 4'd15;
`endif
  logic [N_LEDS-1:0] leds;
  logic              step_tick;
  logic [1:0]        mode_cur;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // model: synchronizer stages, mode, cycles into current step, steps since entry
  int m_s1, m_s2, m_mode, m_cnt, m_steps, m_tick;

  led_pattern_sequencer #(.CLK_DIV(CLK_DIV), .N_LEDS(N_LEDS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode_in   (mode_in),
    .hold      (hold),
`ifdef LED_PWM_DIM_EN
    .dim_level (dim_level),
`endif
    .leds      (leds),
    .step_tick (step_tick),
    .mode_cur  (mode_cur)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [N_LEDS-1:0] model_leds();
    case (m_mode)
      0:       return '0;
      1:       return '1;
      2:       return (m_steps % 2 == 0) ? '1 : '0;
      default: return N_LEDS'(1 << (m_steps % N_LEDS));
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_mode = 0; m_cnt = 0; m_steps = 0; m_tick = 0;
  endtask

  // driver: one clock, model advances on the same edge, expectation queued
  task automatic step();
    @(posedge clk);
    if (reset_n) begin
      if (m_s2 != m_mode) begin
        m_mode = m_s2; m_cnt = 0; m_steps = 0; m_tick = 0;
      end else if (hold) begin
        m_tick = 0;
      end else if (m_cnt == CLK_DIV - 1) begin
        m_cnt = 0; m_steps++; m_tick = 1;
      end else begin
        m_cnt++; m_tick = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(mode_in);
    end
    @(negedge clk);
    exp_q.push_back({model_leds(), 1'(m_tick), 2'(m_mode)});
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    reset_n = 1'b0; mode_in = 2'd3; hold = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL reset_hold act=%h exp=%h", {leds, step_tick, mode_cur}, e);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL reset_release edge%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
    end
    checks++;
    if ({leds, mode_cur} !== {4'h1, 2'd3}) begin
      errors++; $display("FAIL reset_entry leds=%h mode=%0d exp leds=1 mode=3", leds, mode_cur);
    end
  endtask

  task automatic test_chase();
    logic [W-1:0] e;
    int ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (step_tick) ticks++;
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL chase cyc%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
    end
    checks++;
    if (ticks !== 5) begin
      errors++; $display("FAIL chase_ticks act=%0d exp=5", ticks);
    end
  endtask

  task automatic test_blink_hold();
    logic [W-1:0] e;
    mode_in = 2'd2;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) hold = 1'b1;
      if (i == 25) hold = 1'b0;
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL blink_hold cyc%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
      if (i == 2) begin
        checks++;
        if (leds !== 4'hF) begin
          errors++; $display("FAIL blink_entry act=%h exp=f", leds);
        end
      end
      if (i >= 15 && i < 25) begin
        checks++;
        if (step_tick !== 1'b0) begin
          errors++; $display("FAIL hold_tick cyc%0d act=%b exp=0", i, step_tick);
        end
      end
    end
  endtask

  task automatic test_change_on_wrap();
    logic [W-1:0] e;
    bit found = 0;
    int ticks = 0;
    mode_in = 2'd3;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL wrap_wait cyc%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
      if (m_mode == 3 && m_steps % N_LEDS == 2 && m_cnt == 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL wrap_timeout act=0 exp=1");
    end
    mode_in = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (step_tick) ticks++;
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL wrap_change edge%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
      if (i == 3) begin
        checks++;
        if ({leds, step_tick, mode_cur} !== {4'hF, 1'b0, 2'd1}) begin
          errors++; $display("FAIL wrap_entry act=%h exp=%h", {leds, step_tick, mode_cur}, {4'hF, 1'b0, 2'd1});
        end
      end
      if (i == 7) begin
        checks++;
        if (ticks !== 1 || step_tick !== 1'b1) begin
          errors++; $display("FAIL wrap_restart ticks=%0d tick=%b exp ticks=1 tick=1", ticks, step_tick);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] e;
    logic [N_LEDS-1:0] want;
    mode_in = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) mode_in = 2'd2;
      if (i == 6) mode_in = 2'd0;
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL glitch cyc%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
      if (i >= 6 && i <= 8) begin
        want = (i == 7) ? 4'hF : 4'h0;
        checks++;
        if (leds !== want) begin
          errors++; $display("FAIL glitch_pattern cyc%0d act=%h exp=%h", i, leds, want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    mode_in = 2'd3;
    repeat (9) begin
      step();
      e = exp_q.pop_front();
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({leds, step_tick, mode_cur} !== '0) begin
      errors++; $display("FAIL async_reset act=%h exp=0", {leds, step_tick, mode_cur});
    end
    step(); e = exp_q.pop_front();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL reacquire edge%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode_in = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 5) == 0);
      step();
      e = exp_q.pop_front(); checks++;
      if ({leds, step_tick, mode_cur} !== e) begin
        errors++; $display("FAIL random cyc%0d act=%h exp=%h", i, {leds, step_tick, mode_cur}, e);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_chase();
    test_blink_hold();
    test_change_on_wrap();
    test_glitch();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
